// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST sequencer.
package mbist_pkg;

    localparam int NUM_ELEM = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_OP,
        S_DRAIN,
        S_DONE
    } state_t;

    // Per-op fields are indexed by op number: bit 0 is the first op.
    typedef struct packed {
        logic [1:0] n_ops;
        logic       dn;
        logic [1:0] we;
        logic [1:0] pol;
    } march_elem_t;

    localparam march_elem_t MARCH_CM [NUM_ELEM] = '{
        '{n_ops: 2'd1, dn: 1'b0, we: 2'b01, pol: 2'b00},
        '{n_ops: 2'd2, dn: 1'b0, we: 2'b10, pol: 2'b10},
        '{n_ops: 2'd2, dn: 1'b0, we: 2'b10, pol: 2'b01},
        '{n_ops: 2'd2, dn: 1'b1, we: 2'b10, pol: 2'b10},
        '{n_ops: 2'd2, dn: 1'b1, we: 2'b10, pol: 2'b01},
        '{n_ops: 2'd1, dn: 1'b0, we: 2'b00, pol: 2'b00}
    };

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Counter-control and memory-port bundle between the sequencer
// and the address counter / memory under test.
interface mbist_march_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cnt_cen;
    logic              cnt_ld;
    logic              cnt_u_d;
    logic [ADDR_W-1:0] cnt_d_in;
    logic [ADDR_W-1:0] cnt_q;
    logic              mem_cs;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cnt_cen, cnt_ld, cnt_u_d, cnt_d_in,
        output mem_cs, mem_we, mem_wdata,
        input  cnt_q, mem_rdata
    );

    modport slave (
        input  cnt_cen, cnt_ld, cnt_u_d, cnt_d_in,
        input  mem_cs, mem_we, mem_wdata,
        output cnt_q, mem_rdata
    );
endinterface

// File: rtl/mbist_cmp.sv
// Read-pending register, data comparator and sticky first-fail capture.
module mbist_cmp #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_elem,
    input  logic [DATA_W-1:0] rdata,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    logic              pend_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        elem_q;
    logic              miss;

    assign miss = pend_q & (rdata != exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            exp_q  <= '0;
            addr_q <= '0;
            elem_q <= '0;
        end else begin
            pend_q <= rd_vld;
            exp_q  <= rd_exp;
            addr_q <= rd_addr;
            elem_q <= rd_elem;
        end
    end

    // Only the first mismatch of a run is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (miss && !fail) begin
            fail      <= 1'b1;
            fail_addr <= addr_q;
            fail_elem <= elem_q;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: steers the external address counter, issues
// memory reads/writes and reports the first failing address/element.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    mbist_march_ctrl_if.master bus
);

    state_t      state_q, state_n;
    logic [2:0]  elem_q, elem_n;
    logic        op_q, op_n;
    march_elem_t cur;
    logic        cur_we, cur_pol;
    logic        last_op, term, accept;
    logic        rd_vld;

    assign cur     = MARCH_CM[elem_q];
    assign cur_we  = cur.we[op_q];
    assign cur_pol = cur.pol[op_q];
    assign last_op = (2'({1'b0, op_q}) + 2'd1) == cur.n_ops;
    // Terminal address is the far end of the current sweep direction.
    assign term    = cur.dn ? (bus.cnt_q == '0) : (&bus.cnt_q);
    assign accept  = start & ((state_q == S_IDLE) | (state_q == S_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            elem_q  <= elem_n;
            op_q    <= op_n;
        end
    end

    always_comb begin
        state_n = state_q;
        elem_n  = elem_q;
        op_n    = op_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_n = S_LOAD;
                    elem_n  = '0;
                    op_n    = 1'b0;
                end
            end
            S_LOAD: begin
                state_n = S_OP;
                op_n    = 1'b0;
            end
            S_OP: begin
                if (!last_op) begin
                    op_n = 1'b1;
                end else if (!term) begin
                    op_n = 1'b0;
                end else if (elem_q != 3'(NUM_ELEM - 1)) begin
                    state_n = S_LOAD;
                    elem_n  = elem_q + 3'd1;
                    op_n    = 1'b0;
                end else begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        bus.cnt_cen   = 1'b0;
        bus.cnt_ld    = 1'b0;
        bus.cnt_u_d   = 1'b0;
        bus.cnt_d_in  = '0;
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        rd_vld        = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                busy         = 1'b1;
                bus.cnt_cen  = 1'b1;
                bus.cnt_ld   = 1'b1;
                bus.cnt_u_d  = ~cur.dn;
                bus.cnt_d_in = cur.dn ? '1 : '0;
            end
            S_OP: begin
                busy          = 1'b1;
                bus.cnt_u_d   = ~cur.dn;
                bus.cnt_cen   = last_op & ~term;
                bus.mem_cs    = 1'b1;
                bus.mem_we    = cur_we;
                bus.mem_wdata = cur_we ? {DATA_W{cur_pol}} : '0;
                rd_vld        = ~cur_we;
            end
            S_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    assign done = (state_q == S_DONE);
    assign pass = done & ~fail;

    mbist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .rd_vld    (rd_vld),
        .rd_exp    ({DATA_W{cur_pol}}),
        .rd_addr   (bus.cnt_q),
        .rd_elem   (elem_q),
        .rdata     (bus.mem_rdata),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: counter and faulty-memory models plus
// an algorithmic March C- reference producing op log and first fail.
module tb_mbist_march_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    localparam int DONE_CYC = 8 + 10 * N;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } op_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] s0  [N];
    logic [DW-1:0] s1  [N];

    // Up/down counter with load, no reset.
    always @(posedge clk) begin
        if (bus.cnt_cen) begin
            if (bus.cnt_ld) bus.cnt_q <= bus.cnt_d_in;
            else if (bus.cnt_u_d) bus.cnt_q <= bus.cnt_q + 1'b1;
            else bus.cnt_q <= bus.cnt_q - 1'b1;
        end
    end

    // Synchronous memory, stuck-at faults applied on the read path.
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) mem[bus.cnt_q] <= bus.mem_wdata;
            else bus.mem_rdata <=
                (mem[bus.cnt_q] & ~s0[bus.cnt_q]) | s1[bus.cnt_q];
        end
    end

    int  checks = 0;
    int  errors = 0;
    op_t got_q[$];
    op_t exp_q[$];

    int  e_nops [6] = '{1, 2, 2, 2, 2, 1};
    bit  e_down [6] = '{0, 0, 0, 1, 1, 0};
    bit  e_wr0  [6] = '{1, 0, 0, 0, 0, 0};
    int  e_pol0 [6] = '{0, 0, 1, 0, 1, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            s0[i] = '0;
            s1[i] = '0;
        end
    endtask

    // Reference: walk the March C- algorithm over an ideal array.
    function automatic void model(output bit f, output int fa,
                                  output int fe);
        logic [DW-1:0] m [N];
        logic [DW-1:0] rd, want;
        int a;
        bit w;
        int p;
        f = 0; fa = 0; fe = 0;
        exp_q.delete();
        for (int e = 0; e < 6; e++)
            for (int k = 0; k < N; k++) begin
                a = e_down[e] ? N - 1 - k : k;
                for (int o = 0; o < e_nops[e]; o++) begin
                    w = (o == 0) ? e_wr0[e] : 1'b1;
                    p = (o == 0) ? e_pol0[e] : 1 - e_pol0[e];
                    want = (p == 1) ? '1 : '0;
                    if (w) begin
                        m[a] = want;
                        exp_q.push_back('{AW'(a), 1'b1, want});
                    end else begin
                        rd = (m[a] & ~s0[a]) | s1[a];
                        if (rd != want && !f) begin
                            f = 1; fa = a; fe = e;
                        end
                        exp_q.push_back('{AW'(a), 1'b0, '0});
                    end
                end
            end
    endfunction

    // Start at cycle 0; returns cycle where done is first seen.
    task automatic run_march(input bit hold, output int cyc,
                             output bit ld1);
        got_q.delete();
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        cyc = 1;
        ld1 = bus.cnt_ld;
        while (!done && cyc < 200) begin
            if (bus.mem_cs)
                got_q.push_back('{bus.cnt_q, bus.mem_we, bus.mem_wdata});
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, pass, fail, fail_addr, fail_elem} !== '0) begin
            errors++;
            $display("FAIL reset_status got %b want 0",
                     {busy, done, pass, fail, fail_addr, fail_elem});
        end
        checks++;
        if ({bus.cnt_cen, bus.cnt_ld, bus.cnt_u_d, bus.cnt_d_in,
             bus.mem_cs, bus.mem_we, bus.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus got nonzero want 0");
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean();
        int cyc, fa, fe;
        bit ld1, f;
        clear_faults();
        model(f, fa, fe);
        run_march(1'b0, cyc, ld1);
        checks++;
        if (cyc !== DONE_CYC) begin
            errors++;
            $display("FAIL clean_done_cycle got %0d want %0d",
                     cyc, DONE_CYC);
        end
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0) begin
            errors++;
            $display("FAIL clean_pass got p=%b f=%b want p=1 f=0",
                     pass, fail);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL clean_op_count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL clean_op[%0d] got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].we !== 1'b1 || got_q[i].data !== 8'h00) begin
                errors++;
                $display("FAIL e0_write[%0d] got we=%b d=%h want 1/00",
                         i, got_q[i].we, got_q[i].data);
            end
        end
        for (int k = 0; k < 4 && 20 + 2 * k < got_q.size(); k++) begin
            checks++;
            if (got_q[20 + 2 * k].addr !== AW'(3 - k)) begin
                errors++;
                $display("FAIL e3_addr[%0d] got %0d want %0d",
                         k, got_q[20 + 2 * k].addr, 3 - k);
            end
        end
    endtask

    task automatic test_stuck0();
        int cyc;
        bit ld1;
        clear_faults();
        s0[2] = 8'h08;
        run_march(1'b0, cyc, ld1);
        checks++;
        if (cyc !== DONE_CYC) begin
            errors++;
            $display("FAIL sa0_done_cycle got %0d want %0d",
                     cyc, DONE_CYC);
        end
        checks++;
        if ({fail, pass, fail_addr, fail_elem} !==
            {1'b1, 1'b0, 2'd2, 3'd2}) begin
            errors++;
            $display("FAIL sa0_result got f=%b p=%b a=%0d e=%0d want 1 0 2 2",
                     fail, pass, fail_addr, fail_elem);
        end
    endtask

    task automatic test_first_fail();
        int cyc;
        bit ld1;
        clear_faults();
        s1[1] = 8'h01;
        s0[3] = 8'hff;
        run_march(1'b0, cyc, ld1);
        checks++;
        if ({fail, fail_addr, fail_elem} !== {1'b1, 2'd1, 3'd1}) begin
            errors++;
            $display("FAIL first_fail got f=%b a=%0d e=%0d want 1 1 1",
                     fail, fail_addr, fail_elem);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        bit ld1;
        clear_faults();
        s1[0] = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (26) tick();
        checks++;
        if (fail !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst got f=%b b=%b want 1 1", fail, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, fail, fail_addr, fail_elem,
             bus.cnt_cen, bus.cnt_ld, bus.cnt_u_d, bus.cnt_d_in,
             bus.mem_cs, bus.mem_we, bus.mem_wdata} !== '0) begin
            errors++;
            $display("FAIL mid_rst_outputs got nonzero want 0");
        end
        @(negedge clk);
        rst = 1'b0;
        clear_faults();
        tick();
        run_march(1'b0, cyc, ld1);
        checks++;
        if (ld1 !== 1'b1 || pass !== 1'b1 || cyc !== DONE_CYC) begin
            errors++;
            $display("FAIL after_rst got ld=%b p=%b cyc=%0d want 1 1 %0d",
                     ld1, pass, cyc, DONE_CYC);
        end
    endtask

    task automatic test_start_hold();
        int cyc, n;
        bit ld1;
        clear_faults();
        s1[2] = 8'h80;
        run_march(1'b1, cyc, ld1);
        checks++;
        if (cyc !== DONE_CYC || fail !== 1'b1) begin
            errors++;
            $display("FAIL hold_run got cyc=%0d f=%b want %0d 1",
                     cyc, fail, DONE_CYC);
        end
        tick();
        checks++;
        if ({busy, done, fail, bus.cnt_ld} !== 4'b1001) begin
            errors++;
            $display("FAIL restart got b/d/f/ld=%b want 1001",
                     {busy, done, fail, bus.cnt_ld});
        end
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL restart_done timeout got done=0 want 1");
        end
    endtask

    task automatic test_random();
        int cyc, fa, fe, nf, a;
        bit ld1, f;
        for (int t = 0; t < 6; t++) begin
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int j = 0; j < nf; j++) begin
                a = $urandom_range(0, N - 1);
                if ($urandom_range(0, 1) == 1)
                    s1[a] = s1[a] | DW'(1 << $urandom_range(0, DW - 1));
                else
                    s0[a] = s0[a] | DW'(1 << $urandom_range(0, DW - 1));
            end
            model(f, fa, fe);
            repeat ($urandom_range(0, 3)) tick();
            run_march(1'b0, cyc, ld1);
            checks++;
            if (fail !== f || pass !== !f || cyc !== DONE_CYC) begin
                errors++;
                $display("FAIL rand%0d_status got f=%b p=%b c=%0d want %b %b %0d",
                         t, fail, pass, cyc, f, !f, DONE_CYC);
            end
            if (f) begin
                checks++;
                if (fail_addr !== AW'(fa) || fail_elem !== 3'(fe)) begin
                    errors++;
                    $display("FAIL rand%0d_capture got a=%0d e=%0d want %0d %0d",
                             t, fail_addr, fail_elem, fa, fe);
                end
            end
            checks++;
            if (got_q !== exp_q) begin
                errors++;
                $display("FAIL rand%0d_oplog got %0d ops want %0d",
                         t, got_q.size(), exp_q.size());
            end
        end
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_clean();
        test_stuck0();
        test_first_fail();
        test_rst_mid();
        test_start_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- sequencer for the MBIST engine. It sits directly upstream of the address `counter`: it drives the counter's `cen`/`ld`/`u_d`/`d_in`, reads back `q` as the memory address, issues read and write operations to the memory under test, and compares the read data. It reports pass or fail with the address and element of the first failure.

## Interface
Parameters:
- `ADDR_W`, 10: address width. It must equal the counter's `length`. N = 2^ADDR_W words.
- `DATA_W`, 8: memory word width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: level; sampled in IDLE or DONE.
- `busy`  out  1: high from LOAD through DRAIN.
- `done`  out  1: high in DONE until the next accepted start.
- `pass`  out  1: `done & ~fail`.
- `fail`  out  1: sticky mismatch flag; cleared on an accepted start.
- `fail_addr`  out  ADDR_W: address of the first mismatch.
- `fail_elem`  out  3: March element (0-5) of the first mismatch.
- `cnt_cen`, `cnt_ld`, `cnt_u_d`  out  1: counter controls.
- `cnt_d_in`  out  ADDR_W: counter load value.
- `cnt_q`  in  ADDR_W: counter output; also the memory address.
- `mem_cs`, `mem_we`  out  1: memory select and write enable. Memory is synchronous, with 1-cycle read latency.
- `mem_wdata`  out  DATA_W: write data.
- `mem_rdata`  in  DATA_W: read data, valid the cycle after a read.

## Operation
- March elements, fixed:
  - e0 ⇑(w0)
  - e1 ⇑(r0,w1)
  - e2 ⇑(r1,w0)
  - e3 ⇓(r0,w1)
  - e4 ⇓(r1,w0)
  - e5 ⇑(r0)
- Data polarity: 0 = all-zeros word; 1 = all-ones word.
- FSM states: IDLE, LOAD, OP, DRAIN, DONE.
- IDLE/DONE → LOAD on start.
  - Clears `fail`, `fail_addr`, `fail_elem` and `done`.
  - Sets element = 0 and op = 0.
- LOAD: one cycle.
  - Drives `cnt_cen=1`, `cnt_ld=1`, `cnt_u_d` = element direction.
  - Drives `cnt_d_in` = 0 for ⇑ and all-ones for ⇓.
  - No memory access in this cycle. Next state is OP.
- OP: one memory operation per cycle (`mem_cs=1`).
  - `mem_we` and `mem_wdata` come from the element table.
  - On the element's last op:
    - Address not terminal (all-ones for ⇑, 0 for ⇓): assert `cnt_cen=1` with `cnt_ld=0` to step, and reset op to 0.
    - Address terminal, element < 5: go to LOAD with element+1.
    - Address terminal, element 5: go to DRAIN.
  - The terminal test uses `cnt_q` compared against a constant. `cout` is not used.
- DRAIN: one cycle.
  - Completes the final pending compare.
  - Then go to DONE (`done=1`).
- Compare pipeline:
  - Each read cycle registers a pending flag, the expected word, `cnt_q` and the element.
  - On the next cycle, `mem_rdata` is compared against the registered expected word.
  - The first mismatch sets `fail` and captures `fail_addr`/`fail_elem`.
  - Later mismatches do not overwrite the captured values.
  - The test runs to completion; a fail never aborts it.
- `start` is ignored while busy.
- Reset values: state IDLE; all outputs 0, including `busy`, `done`, `pass`, `fail`, `fail_addr`, `fail_elem`, `cnt_*`, `mem_*`.
- Reset mid-test:
  - Returns immediately to IDLE and discards the pending compare.
  - The counter has no reset; every element begins with LOAD, so counter contents are never trusted.

## Timing
- Cycle count per element: 1 + ops × N.
- Total LOAD+OP cycles: 6 + 10N.
- Relative to the first LOAD cycle (cycle 1):
  - DRAIN is at cycle 7 + 10N.
  - `done` is high from cycle 8 + 10N.
- Counter step and memory access share an edge. The memory samples the old `cnt_q` on the same edge at which the counter advances.
- A compare result, and therefore `fail`, becomes visible 2 cycles after the read's OP cycle.

## Structure
- `mbist_pkg` contains:
  - the state enum;
  - the `march_elem_t` struct (op count, direction, per-op we, per-op data polarity);
  - the localparam element table `MARCH_CM[6]`;
  - `NUM_ELEM = 6`.
- Sub-module `mbist_cmp`: the read-pending register, comparator and first-fail capture.
- The counter is instantiated beside this block in the MBIST top, not inside it.

## Test plan
- Fault-free memory, `ADDR_W=2`, `DATA_W=8`, start pulse → `done` at cycle 48, `pass=1`, `fail=0`.
  - Write sequence: 4 writes of 0x00.
  - Element e3 visits addresses 3, 2, 1, 0.
- Bit 3 at address 2 stuck-at-0 → `fail=1`, `fail_addr=2`, `fail_elem=2`, `pass=0`; `done` still at cycle 48.
- Bit 0 at address 1 stuck-at-1 → `fail_addr=1`, `fail_elem=1`.
  - A second fault injected at address 3 does not change the captured values.
- `rst` asserted mid-e3 → all outputs 0 immediately.
  - A new start then passes on a clean memory, with `cnt_ld` pulsed in the first cycle.
- `start` held high during the run → no restart.
  - In DONE, `start` → LOAD next cycle, with `fail`/`done` cleared.
